// File: rtl/wb_trace_streamer_pkg.sv
// Shared record layout, stream length and serializer states for wb_trace_streamer.
// Build option: define WB_TRACE_TIMESTAMP_EN to append a 32-bit cycle stamp to every record.
package trace_pkg;

`ifdef WB_TRACE_TIMESTAMP_EN
  localparam int RLEN = 9;
  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] data;
    logic [2:0]  seq;
    logic [4:0]  rd;
  } rec_t;
`else
  localparam int RLEN = 5;
  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  seq;
    logic [4:0]  rd;
  } rec_t;
`endif

  localparam int REC_W = $bits(rec_t);
  localparam int IDX_W = $clog2(RLEN);

  typedef enum logic {IDLE, SEND} state_t;

  // Field order puts stream byte 0 in the low octet, so byte n is simply octet n.
  function automatic logic [7:0] rec_byte(input rec_t rec, input logic [IDX_W-1:0] idx);
    logic [REC_W-1:0] flat;
    flat = rec;
    return flat[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/wb_trace_streamer_if.sv
// Writeback capture strobe plus byte-stream handshake toward the host link.
// Build option WB_TRACE_TIMESTAMP_EN does not change this interface.
interface wb_trace_streamer_if;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;

  modport master (
    output wb_reg_write, wb_rd, wb_data, tx_ready,
    input  tx_valid, tx_data
  );

  modport slave (
    input  wb_reg_write, wb_rd, wb_data, tx_ready,
    output tx_valid, tx_data
  );
endinterface

// File: rtl/wb_trace_streamer_fifo.sv
// Generic synchronous FIFO with occupancy count; full is the extra count bit.
// Independent of the WB_TRACE_TIMESTAMP_EN build option (width comes in as a parameter).
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = level[AW];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/wb_trace_streamer.sv
// Captures CPU register writebacks into a record FIFO and streams them out byte-wise.
// Build option: WB_TRACE_TIMESTAMP_EN adds a free-running cycle stamp to each record.
module wb_trace_streamer
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   trace_en,
  input  logic                   ovf_clear,
  wb_trace_streamer_if.slave     bus,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count,
  output logic [$clog2(DEPTH):0] fifo_level
);
  logic             qual, accept, drop, pop;
  logic             fifo_empty, fifo_full;
  logic [2:0]       seq;
  rec_t             in_rec, head_rec, cur_rec;
  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0]      ts_cnt;
`endif

  assign qual   = bus.wb_reg_write && (bus.wb_rd != 5'd0) && trace_en;
  assign accept = qual && (!fifo_full || pop);
  assign drop   = qual && !accept;

  always_comb begin
    in_rec      = '0;
    in_rec.seq  = seq;
    in_rec.rd   = bus.wb_rd;
    in_rec.data = bus.wb_data;
`ifdef WB_TRACE_TIMESTAMP_EN
    in_rec.ts   = ts_cnt;
`endif
  end

  trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .pop     (pop),
    .wdata   (in_rec),
    .rdata   (head_rec),
    .level   (fifo_level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Sequence advances on every qualifying event so the host sees gaps for drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (qual) seq <= seq + 3'd1;
      if (ovf_clear) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
      end
    end
  end

`ifdef WB_TRACE_TIMESTAMP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    pop          = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SEND;
          idx_nxt   = '0;
        end
      end
      SEND: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = rec_byte(cur_rec, idx);
        if (bus.tx_ready) begin
          if (idx == IDX_W'(RLEN - 1)) begin
            // Chain straight into the next record when one is waiting.
            idx_nxt = '0;
            if (fifo_empty) state_nxt = IDLE;
            else            pop       = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) cur_rec <= head_rec;
  end
endmodule

// File: tb/tb_wb_trace_streamer.sv
// Self-checking bench for wb_trace_streamer: byte-stream scoreboard plus occupancy/drop model.
// Works with or without WB_TRACE_TIMESTAMP_EN defined.
`timescale 1ns/1ps
module tb_wb_trace_streamer;
  import trace_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk       = 1'b0;
  logic              reset_n   = 1'b0;
  logic              trace_en  = 1'b0;
  logic              ovf_clear = 1'b0;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;
  logic [LW-1:0]     fifo_level;

  wb_trace_streamer_if bus();

  wb_trace_streamer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trace_en   (trace_en),
    .ovf_clear  (ovf_clear),
    .bus        (bus),
    .overflow   (overflow),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int errors  = 0;
  int checks  = 0;
  int chk_pos = 0;

  logic [7:0] exp_q[$];
  logic [7:0] act_q[$];

  // Reference model: records waiting, bytes left in the record on the wire, seq/drop state.
  int                m_cnt   = 0;
  int                m_left  = 0;
  logic [2:0]        m_seq   = '0;
  logic              m_ovf   = 1'b0;
  logic [DROP_W-1:0] m_drops = '0;
  logic [31:0]       m_cyc   = '0;
  logic              m_hs, m_pop, m_qual, m_acc;

  // Inputs change just after the rising edge, so the falling edge sees what the next rising edge will sample.
  always @(negedge clk) begin
    if (!reset_n) begin
      m_cnt   = 0;
      m_left  = 0;
      m_seq   = '0;
      m_ovf   = 1'b0;
      m_drops = '0;
      m_cyc   = '0;
      exp_q.delete();
      act_q.delete();
    end else begin
      if (bus.tx_valid && bus.tx_ready) act_q.push_back(bus.tx_data);
      m_hs   = (m_left > 0) && bus.tx_ready;
      m_pop  = (m_cnt > 0) && ((m_left == 0) || (m_hs && m_left == 1));
      m_qual = bus.wb_reg_write && (bus.wb_rd != 5'd0) && trace_en;
      m_acc  = m_qual && ((m_cnt < DEPTH) || m_pop);
      if (m_hs) m_left--;
      if (m_pop) begin
        m_cnt--;
        m_left = RLEN;
      end
      if (m_acc) begin
        m_cnt++;
        exp_q.push_back({m_seq, bus.wb_rd});
        for (int k = 0; k < 4; k++) exp_q.push_back(bus.wb_data[8*k +: 8]);
`ifdef WB_TRACE_TIMESTAMP_EN
        for (int k = 0; k < 4; k++) exp_q.push_back(m_cyc[8*k +: 8]);
`endif
      end
      if (ovf_clear) begin
        m_ovf   = 1'b0;
        m_drops = '0;
      end else if (m_qual && !m_acc) begin
        m_ovf = 1'b1;
        if (m_drops != {DROP_W{1'b1}}) m_drops = m_drops + 1'b1;
      end
      if (m_qual) m_seq = m_seq + 3'd1;
      m_cyc = m_cyc + 32'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] d);
    bus.wb_reg_write = 1'b1;
    bus.wb_rd        = rd;
    bus.wb_data      = d;
    tick();
    bus.wb_reg_write = 1'b0;
  endtask

  task automatic apply_reset();
    bus.wb_reg_write = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    chk_pos = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (act_q.size() < exp_q.size() && n < 400) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %0b, expected 0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %02h, expected 00", bus.tx_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0b, expected 0", overflow); end
    checks++; if (drop_count !== '0) begin errors++; $display("FAIL rst_drop_count: got %0d, expected 0", drop_count); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rst_fifo_level: got %0d, expected 0", fifo_level); end
    reset_n = 1'b1;
    chk_pos = 0;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] db [4];
    db = '{8'h78, 8'h56, 8'h34, 8'h12};
    trace_en     = 1'b1;
    bus.tx_ready = 1'b1;
    wr(5'd5, 32'h1234_5678);
    checks++; if (fifo_level !== LW'(1)) begin errors++; $display("FAIL single_level_after_capture: got %0d, expected 1", fifo_level); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %0b, expected 0", bus.tx_valid); end
    tick();
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h05) begin
      errors++; $display("FAIL single_byte0: got valid=%0b data=%02h, expected valid=1 data=05", bus.tx_valid, bus.tx_data);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== db[k]) begin
        errors++; $display("FAIL single_byte%0d: got valid=%0b data=%02h, expected valid=1 data=%02h", k + 1, bus.tx_valid, bus.tx_data, db[k]);
      end
    end
    for (int k = 0; k < RLEN - 5; k++) tick();
    tick();
    checks++;
    if (bus.tx_valid !== 1'b0 || fifo_level !== '0) begin
      errors++; $display("FAIL single_done: got valid=%0b level=%0d, expected valid=0 level=0", bus.tx_valid, fifo_level);
    end
  endtask

  task automatic test_filtered();
    int nv;
    apply_reset();
    trace_en = 1'b1;
    wr(5'd0, 32'hFFFF_FFFF);
    trace_en = 1'b0;
    wr(5'd3, 32'hA5A5_A5A5);
    trace_en = 1'b1;
    nv = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.tx_valid !== 1'b0 || fifo_level !== '0) nv++;
    end
    checks++; if (nv != 0) begin errors++; $display("FAIL filtered_quiet: got %0d active cycles, expected 0", nv); end
    wr(5'd1, 32'hCAFE_F00D);
    tick();
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h01) begin
      errors++; $display("FAIL filtered_next_byte0: got valid=%0b data=%02h, expected valid=1 data=01", bus.tx_valid, bus.tx_data);
    end
    repeat (RLEN + 2) tick();
  endtask

  task automatic test_back_to_back();
    int nv;
    bus.tx_ready = 1'b1;
    wr(5'd10, $urandom);
    wr(5'd11, $urandom);
    wr(5'd12, $urandom);
    nv = 0;
    for (int k = 0; k < 3 * RLEN - 1; k++) begin
      if (bus.tx_valid === 1'b1) nv++;
      tick();
    end
    checks++; if (nv != 3 * RLEN - 1) begin errors++; $display("FAIL b2b_valid_run: got %0d valid cycles, expected %0d", nv, 3 * RLEN - 1); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got %0b, expected 0", bus.tx_valid); end
    drain();
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_stream_len: got %0d bytes, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = chk_pos; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_stream_byte[%0d]: got %02h, expected %02h", i, act_q[i], exp_q[i]); end
    end
    chk_pos = exp_q.size();
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [7:0]  hold;
    d = $urandom;
    bus.tx_ready = 1'b1;
    wr(5'd7, d);
    repeat (3) tick();
    bus.tx_ready = 1'b0;
    hold = bus.tx_data;
    checks++; if (hold !== d[15:8]) begin errors++; $display("FAIL bp_byte2: got %02h, expected %02h", hold, d[15:8]); end
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin
        bus.wb_reg_write = 1'b1;
        bus.wb_rd        = 5'd12;
        bus.wb_data      = $urandom;
      end
      tick();
      bus.wb_reg_write = 1'b0;
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== hold) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%0b data=%02h, expected valid=1 data=%02h", k, bus.tx_valid, bus.tx_data, hold);
      end
    end
    bus.tx_ready = 1'b1;
    drain();
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_stream_len: got %0d bytes, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = chk_pos; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_stream_byte[%0d]: got %02h, expected %02h", i, act_q[i], exp_q[i]); end
    end
    chk_pos = exp_q.size();
  endtask

  task automatic test_overflow();
    apply_reset();
    bus.tx_ready = 1'b0;
    trace_en     = 1'b1;
    for (int i = 0; i < 20; i++) wr(5'(i + 1), $urandom);
    // The first record moves into the stalled serializer, so 17 are held and 3 dropped.
    checks++; if (fifo_level !== LW'(16)) begin errors++; $display("FAIL ovf_level: got %0d, expected 16", fifo_level); end
    checks++; if (drop_count !== DROP_W'(3)) begin errors++; $display("FAIL ovf_drop_count: got %0d, expected 3", drop_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b, expected 1", overflow); end
    ovf_clear = 1'b1;
    wr(5'd2, $urandom);
    ovf_clear = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_count !== '0) begin
      errors++; $display("FAIL ovf_clear_wins: got flag=%0b count=%0d, expected flag=0 count=0", overflow, drop_count);
    end
    wr(5'd3, $urandom);
    checks++;
    if (overflow !== 1'b1 || drop_count !== DROP_W'(1)) begin
      errors++; $display("FAIL ovf_redrop: got flag=%0b count=%0d, expected flag=1 count=1", overflow, drop_count);
    end
    bus.tx_ready = 1'b1;
    drain();
    checks++;
    if (act_q.size() != 17 * RLEN) begin
      errors++; $display("FAIL ovf_drained_bytes: got %0d, expected %0d", act_q.size(), 17 * RLEN);
    end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ovf_stream_len: got %0d bytes, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = chk_pos; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_stream_byte[%0d]: got %02h, expected %02h", i, act_q[i], exp_q[i]); end
    end
    chk_pos = exp_q.size();
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_count !== '0) begin
      errors++; $display("FAIL ovf_clear_pulse: got flag=%0b count=%0d, expected flag=0 count=0", overflow, drop_count);
    end
  endtask

  task automatic test_reset_mid();
    int nv;
    bus.tx_ready = 1'b1;
    wr(5'd4, $urandom);
    wr(5'd6, $urandom);
    wr(5'd8, $urandom);
    tick();
    checks++; if (fifo_level !== LW'(2)) begin errors++; $display("FAIL rmid_level_before: got %0d, expected 2", fifo_level); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_tx_valid: got %0b, expected 0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rmid_tx_data: got %02h, expected 00", bus.tx_data); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rmid_fifo_level: got %0d, expected 0", fifo_level); end
    tick();
    tick();
    reset_n = 1'b1;
    chk_pos = 0;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.tx_valid !== 1'b0) nv++;
    end
    checks++; if (nv != 0) begin errors++; $display("FAIL rmid_quiet: got %0d valid cycles, expected 0", nv); end
    wr(5'd9, $urandom);
    tick();
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h09) begin
      errors++; $display("FAIL rmid_byte0: got valid=%0b data=%02h, expected valid=1 data=09", bus.tx_valid, bus.tx_data);
    end
    drain();
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rmid_stream_len: got %0d bytes, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = chk_pos; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_stream_byte[%0d]: got %02h, expected %02h", i, act_q[i], exp_q[i]); end
    end
    chk_pos = exp_q.size();
  endtask

  task automatic test_random();
    int rp_tab [6];
    rp_tab = '{90, 10, 50, 0, 100, 30};
    for (int b = 0; b < 6; b++) begin
      for (int c = 0; c < 120; c++) begin
        bus.wb_reg_write = ($urandom % 100) < 70;
        bus.wb_rd        = 5'($urandom);
        bus.wb_data      = $urandom;
        trace_en         = ($urandom % 8) != 0;
        bus.tx_ready     = ($urandom % 100) < rp_tab[b];
        ovf_clear        = ($urandom % 64) == 0;
        tick();
        checks++; if (fifo_level !== LW'(m_cnt)) begin errors++; $display("FAIL rnd_level: got %0d, expected %0d", fifo_level, m_cnt); end
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow: got %0b, expected %0b", overflow, m_ovf); end
        checks++; if (drop_count !== m_drops) begin errors++; $display("FAIL rnd_drop_count: got %0d, expected %0d", drop_count, m_drops); end
        checks++; if (bus.tx_valid !== (m_left > 0)) begin errors++; $display("FAIL rnd_tx_valid: got %0b, expected %0b", bus.tx_valid, (m_left > 0)); end
      end
    end
    bus.wb_reg_write = 1'b0;
    ovf_clear        = 1'b0;
    trace_en         = 1'b1;
    bus.tx_ready     = 1'b1;
    drain();
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rnd_stream_len: got %0d bytes, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = chk_pos; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_stream_byte[%0d]: got %02h, expected %02h", i, act_q[i], exp_q[i]); end
    end
    chk_pos = exp_q.size();
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rnd_final_level: got %0d, expected 0", fifo_level); end
  endtask

  initial begin
    bus.wb_reg_write = 1'b0;
    bus.wb_rd        = '0;
    bus.wb_data      = '0;
    bus.tx_ready     = 1'b0;
    test_reset();
    test_single();
    test_filtered();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
